// File: rtl/bridge_arbiter.sv
// bridge_arbiter: two-port round-robin arbiter in front of the DRAM bridge
// client port. Each port buffers one request. One transaction is in flight
// at a time. The bridge-side payload is held stable until the bridge
// answers, and the response is routed back to the granted port.
module bridge_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic              req0_r_wb,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data_w,
  input  logic              req1_valid,
  input  logic              req1_r_wb,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data_w,
  output logic              req0_busy,
  output logic              req1_busy,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_data,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_data,
  output logic              C_in_valid,
  output logic              C_r_wb,
  output logic [ADDR_W-1:0] C_addr,
  output logic [DATA_W-1:0] C_data_w,
  input  logic              C_out_valid,
  input  logic [DATA_W-1:0] C_data_r
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t            state;
  state_t            state_next;

  // Per-port holding registers
  logic              pend0;
  logic              r_wb0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] data0;
  logic              pend1;
  logic              r_wb1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] data1;

  logic              rr;      // preferred port when both are pending
  logic              gnt;     // port owning the current transaction
  logic              pick;    // port that would win arbitration now
  logic              start;   // IDLE is launching a transaction
  logic              done;    // bridge answered while we wait for it
  logic              finish;  // last cycle of the transaction (RESP)

  assign req0_busy = pend0;
  assign req1_busy = pend1;

  // Arbitration choice, next-state decode and transaction events
  always_comb begin
    state_next = state;
    pick       = 1'b0;
    start      = 1'b0;
    done       = 1'b0;
    finish     = 1'b0;
    if (pend0 && pend1) begin
      pick = rr;
    end else if (pend1) begin
      pick = 1'b1;
    end else begin
      pick = 1'b0;
    end
    case (state)
      IDLE: begin
        if (pend0 || pend1) begin
          start      = 1'b1;
          state_next = ISSUE;
        end else begin
          state_next = IDLE;
        end
      end
      ISSUE: state_next = WAIT;
      WAIT: begin
        // A bridge completion is only meaningful while we are waiting for one
        if (C_out_valid) begin
          done       = 1'b1;
          state_next = RESP;
        end else begin
          state_next = WAIT;
        end
      end
      RESP: begin
        finish     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Holding registers: accept only when empty, release when own grant finishes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend0 <= 1'b0;
      r_wb0 <= 1'b0;
      addr0 <= {ADDR_W{1'b0}};
      data0 <= {DATA_W{1'b0}};
      pend1 <= 1'b0;
      r_wb1 <= 1'b0;
      addr1 <= {ADDR_W{1'b0}};
      data1 <= {DATA_W{1'b0}};
    end else begin
      if (req0_valid && !pend0) begin
        pend0 <= 1'b1;
        r_wb0 <= req0_r_wb;
        addr0 <= req0_addr;
        data0 <= req0_data_w;
      end else if (finish && !gnt) begin
        pend0 <= 1'b0;
      end
      if (req1_valid && !pend1) begin
        pend1 <= 1'b1;
        r_wb1 <= req1_r_wb;
        addr1 <= req1_addr;
        data1 <= req1_data_w;
      end else if (finish && gnt) begin
        pend1 <= 1'b0;
      end
    end
  end

  // Grant latch and round-robin pointer (flips away from the port just served)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt <= 1'b0;
      rr  <= 1'b0;
    end else begin
      if (start) begin
        gnt <= pick;
      end
      if (finish) begin
        rr <= ~gnt;
      end
    end
  end

  // Bridge-side payload: loaded at launch, held through WAIT, zeroed on completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      C_in_valid <= 1'b0;
      C_r_wb     <= 1'b0;
      C_addr     <= {ADDR_W{1'b0}};
      C_data_w   <= {DATA_W{1'b0}};
    end else begin
      C_in_valid <= start;
      if (start) begin
        C_r_wb   <= pick ? r_wb1 : r_wb0;
        C_addr   <= pick ? addr1 : addr0;
        C_data_w <= pick ? data1 : data0;
      end else if (done) begin
        C_r_wb   <= 1'b0;
        C_addr   <= {ADDR_W{1'b0}};
        C_data_w <= {DATA_W{1'b0}};
      end
    end
  end

  // Response pulses: read data for reads, zero for writes and when idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp0_valid <= 1'b0;
      rsp0_data  <= {DATA_W{1'b0}};
      rsp1_valid <= 1'b0;
      rsp1_data  <= {DATA_W{1'b0}};
    end else begin
      rsp0_valid <= done && !gnt;
      rsp1_valid <= done && gnt;
      rsp0_data  <= (done && !gnt && C_r_wb) ? C_data_r : {DATA_W{1'b0}};
      rsp1_data  <= (done && gnt && C_r_wb) ? C_data_r : {DATA_W{1'b0}};
    end
  end

endmodule
